pcm_receiver: RTL and testbench
===============================

# pcm_receiver

- Serial PCM receiver and frame synchronizer; sits directly downstream of the PCM transmitter.
- Oversamples the serial PCM clock/data pair in the `clk_i` domain, hunts for the configurable synchronous code and locks to the frame with a flywheel.
- Delivers data bytes with frame markers.
- Checks the incrementing 0x00–0xff test pattern and counts errors, for loopback and link test.

## Interface
- `LOCK_MISS`, default 2: consecutive sync-code mismatches tolerated before dropping lock (range 1–15).
- `SYNC_STAGES`, default 2: synchronizer flops on `pcm_clk_i` and `pcm_data_i` (range 2–3).
- `clk_i` in, 1 bit: main clock. Must be at least 4× the `pcm_clk_i` frequency.
- `rst_i` in, 1 bit: asynchronous, active-high reset.
- `enable_i` in, 1 bit: 0 forces HUNT and holds outputs idle.
- `pcm_clk_i` in, 1 bit: serial clock, asynchronous to `clk_i`.
- `pcm_data_i` in, 1 bit: serial data, MSB first, asynchronous to `clk_i`.
- `edge_i` in, 1 bit: 0 samples on `pcm_clk_i` falling edge; 1 samples on rising edge.
- `code_i` in, 32 bits: sync code, right-aligned.
- `number_i` in, 2 bits: sync length. 0 = 4 bytes, 1 = 3, 2 = 2, 3 = 1 byte. Compare width is 32−8·`number_i` bits.
- `length_i` in, 16 bits: data bytes per frame after the sync code. 0 is treated as 1.
- `byte_o` out, 8 bits: received data byte.
- `byte_valid_o` out, 1 bit: single-cycle strobe, `byte_o` valid.
- `sof_o` out, 1 bit: coincident with `byte_valid_o` on the first data byte of a frame.
- `eof_o` out, 1 bit: coincident with `byte_valid_o` on the last data byte of a frame.
- `locked_o` out, 1 bit: high in DATA and VERIFY.
- `sync_err_o` out, 1 bit: single-cycle pulse on each sync-code mismatch in VERIFY.
- `frame_cnt_o` out, 32 bits: completed frames since lock. Saturates at all-ones.
- `err_cnt_o` out, 32 bits: test-pattern byte mismatches. Saturates at all-ones.
- Reset values: all outputs 0.

## Operation
- **Edge detection:** `pcm_clk_i` and `pcm_data_i` pass through `SYNC_STAGES` flops. One further register on the clock gives edge detect. The selected edge raises the internal `bit_stb` for one cycle; the synchronized data bit is shifted in on that cycle.
- **32-bit shift register:** always shifts on `bit_stb` in every state.
- **HUNT:**
  - On every `bit_stb`, compare the low 32−8·`number_i` bits of the shift register (including the new bit) with the same bits of `code_i`.
  - On match, go to DATA with the bit counter and byte counter cleared.
  - `frame_cnt_o` and the miss counter are cleared on entering DATA from HUNT.
- **DATA:**
  - Every 8th `bit_stb` emits a byte.
  - After `length_i` bytes, go to VERIFY with the bit counter cleared.
- **VERIFY:**
  - Collect 32−8·`number_i` bits, then compare with `code_i` (masked).
  - On match: clear the miss counter and return to DATA.
  - On mismatch: pulse `sync_err_o` and increment the miss counter.
    - If the miss counter reaches `LOCK_MISS`, go to HUNT.
    - Otherwise return to DATA (flywheel).
  - `frame_cnt_o` increments on the `eof_o` byte.
- **Pattern check:**
  - The first byte after a HUNT→DATA lock seeds the expected value and is not checked.
  - Each subsequent byte is compared with the previous byte +1 mod 256. This continues across frame boundaries and across flywheel frames.
  - On mismatch, increment `err_cnt_o` and reseed the expected value from the received byte.
- **Clearing and config changes:**
  - `err_cnt_o` clears only on reset.
  - `enable_i` low clears state to HUNT and clears the bit, byte and miss counters.
  - A change to `code_i`, `number_i` or `length_i` while locked takes effect at the next comparison or frame boundary; no special handling.
- **Reset mid-frame:** all state returns to HUNT immediately. A partial byte is discarded and no strobe is produced.

## Timing
- `bit_stb` occurs `SYNC_STAGES`+1 `clk_i` cycles after the pin edge.
- `byte_valid_o`, `sof_o` and `eof_o` assert in the cycle after the `bit_stb` of the 8th bit. They last 1 cycle.
- `byte_o` holds its value until the next strobe.
- `locked_o` rises in the cycle after the matching `bit_stb` in HUNT. It falls in the cycle after the final failing VERIFY `bit_stb`.
- Each of `bit_stb`, `byte_valid_o` and `sync_err_o` occurs at most once per `pcm_clk_i` period.
- There is no backpressure; the consumer must accept every strobe.

## Structure
- Shared package `pcm_pkg` holds:
  - the state enum (HUNT, DATA, VERIFY);
  - a sync-width function (`number_i` → bit count 32/24/16/8);
  - a mask function (`number_i` → 32-bit compare mask).
- The transmitter reuses these functions.
- Sub-module `pcm_edge_sync`: synchronizer, edge detect and `edge_i` select. It outputs `bit_stb` and `bit_data`.

## Test plan
- `code_i`=0xEB90_146F, `number_i`=0, `length_i`=4, serial bytes 0x10–0x13 after the code:
  - `sof_o` on 0x10 and `eof_o` on 0x13;
  - `locked_o`=1;
  - `frame_cnt_o`=1 after the first frame;
  - `err_cnt_o`=0.
- `number_i`=3, `code_i`=0x0000_0090, byte 0x90 embedded in noise before the true sync:
  - locks on the first 0x90;
  - VERIFY mismatches pulse `sync_err_o` twice, then HUNT;
  - relocks on the true sync.
- `LOCK_MISS`=2, one corrupted sync code mid-stream:
  - one `sync_err_o` pulse;
  - `locked_o` stays 1;
  - bytes keep flowing.
- Data stream 0x05, 0x06, 0x08, 0x09:
  - `err_cnt_o`=1 after 0x08;
  - 0x09 is accepted with no further error.
- `edge_i`=1 versus `edge_i`=0 with data changing on the opposite edge: both recover identical bytes.
- `rst_i` pulsed mid-byte:
  - all outputs 0 immediately;
  - no `byte_valid_o` until a fresh sync code is received.

Source files
------------

// File: rtl/pcm_pkg.sv
// ---------------------------------------------------------------------------
// pcm_pkg: shared PCM framing types and sync-code width/mask helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pcm_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        VERIFY = 2'd2
    } pcm_state_t;

    // number: 0 = 4-byte code, 1 = 3, 2 = 2, 3 = 1 byte
    function automatic logic [5:0] sync_width(input logic [1:0] number);
        logic [5:0] width;
        case (number)
            2'd0:    width = 6'd32;
            2'd1:    width = 6'd24;
            2'd2:    width = 6'd16;
            default: width = 6'd8;
        endcase
        return width;
    endfunction

    function automatic logic [31:0] sync_mask(input logic [1:0] number);
        logic [31:0] mask;
        case (number)
            2'd0:    mask = 32'hFFFF_FFFF;
            2'd1:    mask = 32'h00FF_FFFF;
            2'd2:    mask = 32'h0000_FFFF;
            default: mask = 32'h0000_00FF;
        endcase
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pcm_edge_sync.sv
// ---------------------------------------------------------------------------
// pcm_edge_sync: synchronizes the PCM clock/data pair and strobes on the selected edge.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pcm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pcm_clk,
    input  logic pcm_data,
    input  logic edge_sel,
    output logic bit_stb,
    output logic bit_data
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;

    // Clock and data use equal-length chains so they stay aligned at the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], pcm_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], pcm_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign bit_stb  = edge_sel ? (clk_s & ~clk_prev) : (~clk_s & clk_prev);
    assign bit_data = data_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pcm_receiver.sv
// ---------------------------------------------------------------------------
// pcm_receiver: serial PCM frame synchronizer with flywheel lock and test-pattern checker.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pcm_receiver
    import pcm_pkg::*;
#(
    parameter int LOCK_MISS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        pcm_clk_i,
    input  logic        pcm_data_i,
    input  logic        edge_i,
    input  logic [31:0] code_i,
    input  logic [1:0]  number_i,
    input  logic [15:0] length_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        locked_o,
    output logic        sync_err_o,
    output logic [31:0] frame_cnt_o,
    output logic [31:0] err_cnt_o
);

    logic        bit_stb;
    logic        bit_data;

    pcm_state_t  state_q;
    pcm_state_t  state_next;
    logic [5:0]  bit_cnt_q;
    logic [5:0]  bit_cnt_next;
    logic [15:0] byte_cnt_q;
    logic [15:0] byte_cnt_next;
    logic [3:0]  miss_q;
    logic [3:0]  miss_next;

    // The incoming bit completes the 32-bit window, so only 31 bits are stored.
    logic [30:0] shift_q;
    logic [31:0] shift_next;
    logic        code_match;
    logic [15:0] frame_len;

    logic        emit;
    logic        emit_sof;
    logic        emit_eof;
    logic        sync_miss;
    logic        lock_acq;
    logic        seed_q;
    logic [7:0]  expect_q;

    pcm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk_i),
        .rst      (rst_i),
        .pcm_clk  (pcm_clk_i),
        .pcm_data (pcm_data_i),
        .edge_sel (edge_i),
        .bit_stb  (bit_stb),
        .bit_data (bit_data)
    );

    assign shift_next = {shift_q, bit_data};
    assign code_match = ((shift_next ^ code_i) & sync_mask(number_i)) == 32'd0;
    assign frame_len  = (length_i == 16'd0) ? 16'd1 : length_i;
    assign locked_o   = (state_q != HUNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_next;
            bit_cnt_q  <= bit_cnt_next;
            byte_cnt_q <= byte_cnt_next;
            miss_q     <= miss_next;
        end
    end

    always_comb begin
        state_next    = state_q;
        bit_cnt_next  = bit_cnt_q;
        byte_cnt_next = byte_cnt_q;
        miss_next     = miss_q;
        emit          = 1'b0;
        emit_sof      = 1'b0;
        emit_eof      = 1'b0;
        sync_miss     = 1'b0;
        lock_acq      = 1'b0;

        if (!enable_i) begin
            state_next    = HUNT;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
            miss_next     = '0;
        end else if (bit_stb) begin
            case (state_q)
                HUNT: begin
                    if (code_match) begin
                        state_next    = DATA;
                        bit_cnt_next  = '0;
                        byte_cnt_next = '0;
                        miss_next     = '0;
                        lock_acq      = 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt_q == 6'd7) begin
                        emit         = 1'b1;
                        emit_sof     = (byte_cnt_q == 16'd0);
                        bit_cnt_next = '0;
                        // >= keeps a shortened length_i from overrunning the frame
                        if (byte_cnt_q >= frame_len - 16'd1) begin
                            emit_eof      = 1'b1;
                            byte_cnt_next = '0;
                            state_next    = VERIFY;
                        end else begin
                            byte_cnt_next = byte_cnt_q + 16'd1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_q + 6'd1;
                    end
                end
                VERIFY: begin
                    if (bit_cnt_q >= sync_width(number_i) - 6'd1) begin
                        bit_cnt_next = '0;
                        state_next   = DATA;
                        if (code_match) begin
                            miss_next = '0;
                        end else begin
                            sync_miss = 1'b1;
                            miss_next = miss_q + 4'd1;
                            if (miss_q + 4'd1 >= 4'(LOCK_MISS)) begin
                                state_next = HUNT;
                            end
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_q + 6'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q      <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            sync_err_o   <= 1'b0;
            frame_cnt_o  <= '0;
            err_cnt_o    <= '0;
            seed_q       <= 1'b0;
            expect_q     <= '0;
        end else begin
            if (bit_stb) begin
                shift_q <= shift_next[30:0];
            end
            byte_valid_o <= emit;
            sof_o        <= emit_sof;
            eof_o        <= emit_eof;
            sync_err_o   <= sync_miss;
            if (emit) begin
                byte_o <= shift_next[7:0];
            end

            if (lock_acq) begin
                frame_cnt_o <= '0;
            end else if (emit_eof && (frame_cnt_o != '1)) begin
                frame_cnt_o <= frame_cnt_o + 32'd1;
            end

            // Expected value always tracks received+1, which also reseeds after an error.
            if (lock_acq) begin
                seed_q <= 1'b1;
            end else if (emit) begin
                seed_q   <= 1'b0;
                expect_q <= shift_next[7:0] + 8'd1;
                if (!seed_q && (shift_next[7:0] != expect_q) && (err_cnt_o != '1)) begin
                    err_cnt_o <= err_cnt_o + 32'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pcm_receiver.sv
// ---------------------------------------------------------------------------
// tb_pcm_receiver: scoreboard bench driving serial PCM frames into pcm_receiver.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pcm_receiver;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        pcm_clk_i;
    logic        pcm_data_i;
    logic        edge_i;
    logic [31:0] code_i;
    logic [1:0]  number_i;
    logic [15:0] length_i;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        sof_o;
    logic        eof_o;
    logic        locked_o;
    logic        sync_err_o;
    logic [31:0] frame_cnt_o;
    logic [31:0] err_cnt_o;

    int          errors        = 0;
    int          checks        = 0;
    int          sync_err_seen = 0;
    logic [9:0]  sb_q[$];

    localparam logic [31:0] SYNC = 32'hEB90_146F;

    always #5 clk_i = ~clk_i;

    pcm_receiver #(
        .LOCK_MISS   (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .pcm_clk_i    (pcm_clk_i),
        .pcm_data_i   (pcm_data_i),
        .edge_i       (edge_i),
        .code_i       (code_i),
        .number_i     (number_i),
        .length_i     (length_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .locked_o     (locked_o),
        .sync_err_o   (sync_err_o),
        .frame_cnt_o  (frame_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer: every strobe must match the next queued expectation.
    always @(negedge clk_i) begin
        logic [9:0] exp_entry;
        if (sync_err_o) sync_err_seen++;
        if (byte_valid_o) begin
            if (sb_q.size() == 0) begin
                check_value("unexpected_strobe", {31'd0, byte_valid_o}, 32'd0);
            end else begin
                exp_entry = sb_q.pop_front();
                check_value("byte", {24'd0, byte_o}, {24'd0, exp_entry[7:0]});
                check_value("sof", {31'd0, sof_o}, {31'd0, exp_entry[9]});
                check_value("eof", {31'd0, eof_o}, {31'd0, exp_entry[8]});
            end
        end else if (sof_o || eof_o) begin
            check_value("flag_without_valid", {30'd0, sof_o, eof_o}, 32'd0);
        end
    end

    task automatic send_bit(input logic b);
        if (edge_i) begin
            pcm_clk_i = 1'b0; pcm_data_i = b; #40;
            pcm_clk_i = 1'b1; #40;
        end else begin
            pcm_clk_i = 1'b1; pcm_data_i = b; #40;
            pcm_clk_i = 1'b0; #40;
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic expect_out,
                             input logic sof, input logic eof);
        if (expect_out) sb_q.push_back({sof, eof, b});
        send_bits({24'd0, b}, 8);
    endtask

    task automatic send_frame(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(first + i), 1'b1, i == 0, i == n - 1);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        pcm_clk_i  = edge_i;
        pcm_data_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        settle();
        sync_err_seen = 0;
    endtask

    initial begin
        rst_i      = 1'b1;
        enable_i   = 1'b1;
        edge_i     = 1'b1;
        pcm_clk_i  = 1'b1;
        pcm_data_i = 1'b0;
        code_i     = SYNC;
        number_i   = 2'd0;
        length_i   = 16'd4;
        repeat (3) @(negedge clk_i);
        check_value("rst_byte", {24'd0, byte_o}, 32'd0);
        check_value("rst_flags", {27'd0, byte_valid_o, sof_o, eof_o, locked_o, sync_err_o}, 32'd0);
        check_value("rst_frame_cnt", frame_cnt_o, 32'd0);
        check_value("rst_err_cnt", err_cnt_o, 32'd0);
        rst_i = 1'b0;
        settle();

        // 4-byte sync, two frames of incrementing data, rising-edge sampling
        send_bits(32'd0, 32);
        settle();
        check_value("t1_unlocked", {31'd0, locked_o}, 32'd0);
        send_bits(SYNC, 32);
        settle();
        check_value("t1_locked", {31'd0, locked_o}, 32'd1);
        send_frame(8'h10, 4);
        settle();
        check_value("t1_frame_cnt1", frame_cnt_o, 32'd1);
        check_value("t1_err_cnt", err_cnt_o, 32'd0);
        send_bits(SYNC, 32);
        send_frame(8'h14, 4);
        settle();
        check_value("t1_frame_cnt2", frame_cnt_o, 32'd2);
        check_value("t1_locked_after", {31'd0, locked_o}, 32'd1);
        check_value("t1_sync_err", 32'(sync_err_seen), 32'd0);
        check_value("t1_sb_drain", 32'(sb_q.size()), 32'd0);

        // Same stream, falling-edge sampling with data changing on the rising edge
        edge_i = 1'b0;
        do_reset();
        send_bits(32'd0, 32);
        send_bits(SYNC, 32);
        send_frame(8'h10, 4);
        settle();
        check_value("t5_frame_cnt", frame_cnt_o, 32'd1);
        check_value("t5_err_cnt", err_cnt_o, 32'd0);
        check_value("t5_sb_drain", 32'(sb_q.size()), 32'd0);

        // 1-byte sync: false lock on an early 0x90, two VERIFY misses, relock
        edge_i   = 1'b1;
        do_reset();
        number_i = 2'd3;
        code_i   = 32'h0000_0090;
        length_i = 16'd1;
        send_bits(32'd0, 8);
        send_bits(32'h90, 8);
        settle();
        check_value("t2_false_lock", {31'd0, locked_o}, 32'd1);
        send_byte(8'h20, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'h21, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        settle();
        check_value("t2_sync_err_two", 32'(sync_err_seen), 32'd2);
        check_value("t2_dropped", {31'd0, locked_o}, 32'd0);
        send_bits(32'd0, 8);
        send_bits(32'h90, 8);
        send_byte(8'h40, 1'b1, 1'b1, 1'b1);
        send_bits(32'h90, 8);
        send_byte(8'h41, 1'b1, 1'b1, 1'b1);
        settle();
        check_value("t2_relocked", {31'd0, locked_o}, 32'd1);
        check_value("t2_frame_cnt", frame_cnt_o, 32'd2);
        check_value("t2_sync_err_total", 32'(sync_err_seen), 32'd2);
        check_value("t2_err_cnt", err_cnt_o, 32'd0);
        check_value("t2_sb_drain", 32'(sb_q.size()), 32'd0);

        // Single corrupted sync code is absorbed by the flywheel
        do_reset();
        number_i = 2'd0;
        code_i   = SYNC;
        length_i = 16'd2;
        send_bits(32'd0, 32);
        send_bits(SYNC, 32);
        send_frame(8'h00, 2);
        send_bits(SYNC, 32);
        send_frame(8'h02, 2);
        send_bits(SYNC ^ 32'h1, 32);
        settle();
        check_value("t3_sync_err_one", 32'(sync_err_seen), 32'd1);
        check_value("t3_still_locked", {31'd0, locked_o}, 32'd1);
        send_frame(8'h04, 2);
        send_bits(SYNC, 32);
        send_frame(8'h06, 2);
        settle();
        check_value("t3_locked_end", {31'd0, locked_o}, 32'd1);
        check_value("t3_sync_err_total", 32'(sync_err_seen), 32'd1);
        check_value("t3_frame_cnt", frame_cnt_o, 32'd4);
        check_value("t3_err_cnt", err_cnt_o, 32'd0);
        check_value("t3_sb_drain", 32'(sb_q.size()), 32'd0);

        // Pattern break 0x05,0x06,0x08,0x09
        do_reset();
        length_i = 16'd4;
        send_bits(32'd0, 32);
        send_bits(SYNC, 32);
        send_byte(8'h05, 1'b1, 1'b1, 1'b0);
        send_byte(8'h06, 1'b1, 1'b0, 1'b0);
        settle();
        check_value("t4_err_before", err_cnt_o, 32'd0);
        send_byte(8'h08, 1'b1, 1'b0, 1'b0);
        settle();
        check_value("t4_err_after_08", err_cnt_o, 32'd1);
        send_byte(8'h09, 1'b1, 1'b0, 1'b1);
        settle();
        check_value("t4_err_after_09", err_cnt_o, 32'd1);
        check_value("t4_frame_cnt", frame_cnt_o, 32'd1);
        check_value("t4_sb_drain", 32'(sb_q.size()), 32'd0);

        // Reset pulsed three bits into a data byte
        do_reset();
        send_bits(32'd0, 32);
        send_bits(SYNC, 32);
        send_frame(8'h30, 4);
        send_bits(SYNC, 32);
        send_bits(32'b001, 3);
        rst_i = 1'b1;
        #1;
        check_value("t6_rst_byte", {24'd0, byte_o}, 32'd0);
        check_value("t6_rst_flags", {27'd0, byte_valid_o, sof_o, eof_o, locked_o, sync_err_o}, 32'd0);
        check_value("t6_rst_frame_cnt", frame_cnt_o, 32'd0);
        check_value("t6_rst_err_cnt", err_cnt_o, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        send_bits(32'b10100, 5);
        send_bits(32'd0, 32);
        settle();
        check_value("t6_no_lock", {31'd0, locked_o}, 32'd0);
        check_value("t6_sb_drain_mid", 32'(sb_q.size()), 32'd0);
        send_bits(SYNC, 32);
        send_frame(8'h50, 4);
        settle();
        check_value("t6_relocked", {31'd0, locked_o}, 32'd1);
        check_value("t6_frame_cnt", frame_cnt_o, 32'd1);
        check_value("t6_sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
